// File: rtl/spi_regbank_if.sv
// spi_regbank_if: SPI pin bundle plus register-bank outputs of spi_regbank.
//   sclk/ncs/copi : SPI controller -> target (raw, asynchronous to clk)
//   cipo/cipo_oe  : SPI target -> controller read data and its output enable
//   regs_out      : flattened register file, reg i at [i*DATA_W +: DATA_W]
//   wr_valid/wr_addr/frame_err : commit pulse, last committed address, frame error pulse
interface spi_regbank_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
);
  logic                         sclk;
  logic                         ncs;
  logic                         copi;
  logic                         cipo;
  logic                         cipo_oe;
  logic [NUM_REGS*DATA_W-1:0]   regs_out;
  logic                         wr_valid;
  logic [ADDR_W-1:0]            wr_addr;
  logic                         frame_err;

  // Register bank side
  modport slave (
    input  sclk, ncs, copi,
    output cipo, cipo_oe, regs_out, wr_valid, wr_addr, frame_err
  );

  // Controller / consumer side
  modport master (
    output sclk, ncs, copi,
    input  cipo, cipo_oe, regs_out, wr_valid, wr_addr, frame_err
  );
endinterface

// File: rtl/spi_regbank.sv
// spi_regbank: mode-0 SPI target register bank running entirely in the clk domain.
// Frame (MSB first): R/W (1=write) | address (ADDR_W) | data (DATA_W).
// Writes commit on ncs rise only after an exact-length, in-range frame; reads
// shift a snapshot of the addressed register out on CIPO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   io_bus     : spi_regbank_if slave modport (SPI pins and register outputs)
module spi_regbank #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_regbank_if.slave   io_bus
);

  localparam int unsigned FRAME   = 1 + ADDR_W + DATA_W;
  localparam int unsigned CMD_LEN = 1 + ADDR_W;
  localparam int unsigned CNT_W   = $clog2(FRAME + 2);
  localparam int unsigned FILL_W  = $clog2(SYNC_STAGES + 1);
  localparam int unsigned LEFT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_OVER
  } state_t;

  // Synchronisers: index 0 is the newest sample, SYNC_STAGES-1 the oldest
  logic [SYNC_STAGES-1:0]      r_sclk_sync;
  logic [SYNC_STAGES-1:0]      r_ncs_sync;
  logic [SYNC_STAGES-1:0]      r_copi_sync;
  logic [FILL_W-1:0]           r_fill;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [FRAME-1:0]            r_sh;
  logic [DATA_W-1:0]           r_shadow;
  logic [LEFT_W-1:0]           r_left;
  logic [NUM_REGS*DATA_W-1:0]  r_regs_out;
  logic                        r_cipo;
  logic                        r_cipo_oe;
  logic                        r_wr_pend;
  logic                        r_err_pend;
  logic [ADDR_W-1:0]           r_wr_addr_pend;
  logic                        r_wr_valid;
  logic [ADDR_W-1:0]           r_wr_addr;
  logic                        r_frame_err;

  logic                        w_live;
  logic                        w_sclk_rise;
  logic                        w_sclk_fall;
  logic                        w_ncs_fall;
  logic                        w_ncs_rise;
  logic                        w_copi_bit;
  logic [FRAME-1:0]            w_sh_next;
  logic [CNT_W-1:0]            w_cnt_inc;
  logic                        w_rw;
  logic [ADDR_W-1:0]           w_addr;
  logic [DATA_W-1:0]           w_data;
  logic [ADDR_W-1:0]           w_ld_addr;
  logic [DATA_W-1:0]           w_rd_val;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
  endfunction

  // Input synchronisers; r_fill masks edges until every stage holds a real sample,
  // so reset values can never fake an ncs fall (a frame needs a fresh ncs fall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_fill      <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_bus.sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  io_bus.ncs};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], io_bus.copi};
      if (r_fill != FILL_W'(SYNC_STAGES)) r_fill <= r_fill + FILL_W'(1);
    end
  end

  // Single-cycle edge events from the last two stages
  assign w_live      = (r_fill == FILL_W'(SYNC_STAGES));
  assign w_sclk_rise = w_live &  r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_fall = w_live & ~r_sclk_sync[SYNC_STAGES-2] &  r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_fall  = w_live & ~r_ncs_sync[SYNC_STAGES-2]  &  r_ncs_sync[SYNC_STAGES-1];
  assign w_ncs_rise  = w_live &  r_ncs_sync[SYNC_STAGES-2]  & ~r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_bit  = r_copi_sync[SYNC_STAGES-1];

  assign w_sh_next = {r_sh[FRAME-2:0], w_copi_bit};
  assign w_cnt_inc = (r_cnt == CNT_W'(FRAME + 1)) ? r_cnt : r_cnt + CNT_W'(1);

  // Fields of a completed frame, valid when r_cnt == FRAME
  assign w_rw   = r_sh[FRAME-1];
  assign w_addr = r_sh[DATA_W +: ADDR_W];
  assign w_data = r_sh[DATA_W-1:0];

  // Address as it completes on the current sclk rise; out-of-range reads as zero
  assign w_ld_addr = w_sh_next[ADDR_W-1:0];
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (w_ld_addr == ADDR_W'(i)) w_rd_val = r_regs_out[i*DATA_W +: DATA_W];
    end
  end

  // Frame FSM, register file, read shifter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_sh           <= '0;
      r_shadow       <= '0;
      r_left         <= '0;
      r_regs_out     <= '0;
      r_cipo         <= 1'b0;
      r_cipo_oe      <= 1'b0;
      r_wr_pend      <= 1'b0;
      r_err_pend     <= 1'b0;
      r_wr_addr_pend <= '0;
      r_wr_valid     <= 1'b0;
      r_wr_addr      <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      // Commit/evaluate decisions surface as pulses one cycle after the ncs-rise cycle
      r_wr_valid <= r_wr_pend;
      r_frame_err <= r_err_pend;
      if (r_wr_pend) r_wr_addr <= r_wr_addr_pend;
      r_wr_pend  <= 1'b0;
      r_err_pend <= 1'b0;

      if (w_ncs_rise) begin
        // ncs rise wins over a coincident sclk rise: that bit is dropped
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_cipo    <= 1'b0;
        r_cipo_oe <= 1'b0;
        r_left    <= '0;
        if (r_state != S_IDLE) begin
          if (r_cnt == CNT_W'(FRAME)) begin
            if (!f_in_range(w_addr)) begin
              r_err_pend <= 1'b1;
            end else if (w_rw) begin
              for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_addr == ADDR_W'(i)) r_regs_out[i*DATA_W +: DATA_W] <= w_data;
              end
              r_wr_pend      <= 1'b1;
              r_wr_addr_pend <= w_addr;
            end
          end else if (r_cnt != '0) begin
            r_err_pend <= 1'b1;
          end
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_ncs_fall) begin
              r_state <= S_CMD;
              r_cnt   <= '0;
              r_sh    <= '0;
            end
          end
          default: begin
            if (w_sclk_rise) begin
              r_cnt <= w_cnt_inc;
              r_sh  <= w_sh_next;
              if (r_state == S_CMD && w_cnt_inc == CNT_W'(CMD_LEN)) begin
                r_state <= S_DATA;
                // Read: snapshot now so later writes cannot disturb this transfer
                if (!w_sh_next[ADDR_W]) begin
                  r_shadow  <= w_rd_val;
                  r_left    <= LEFT_W'(DATA_W);
                  r_cipo    <= w_rd_val[DATA_W-1];
                  r_cipo_oe <= 1'b1;
                end
              end else if (r_state == S_DATA && w_cnt_inc == CNT_W'(FRAME + 1)) begin
                r_state <= S_OVER;
              end
            end
            // First fall after the load re-presents the MSB; zeros after DATA_W bits
            if (w_sclk_fall && r_cipo_oe) begin
              if (r_left != '0) begin
                r_cipo   <= r_shadow[DATA_W-1];
                r_shadow <= r_shadow << 1;
                r_left   <= r_left - LEFT_W'(1);
              end else begin
                r_cipo <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign io_bus.cipo      = r_cipo;
  assign io_bus.cipo_oe   = r_cipo_oe;
  assign io_bus.regs_out  = r_regs_out;
  assign io_bus.wr_valid  = r_wr_valid;
  assign io_bus.wr_addr   = r_wr_addr;
  assign io_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: two spi_regbank instances (default geometry and a 16x16/ADDR_W=4
// sweep) driven by an SPI controller model, checked against a register-array model.
`timescale 1ns/1ps
module tb_spi_regbank;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_regbank_if #(.NUM_REGS(8),  .DATA_W(8),  .ADDR_W(7)) bus0 ();
  spi_regbank_if #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) bus1 ();

  spi_regbank #(.NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus0)
  );
  spi_regbank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1)
  );

  logic         sclk_d [2];
  logic         ncs_d  [2];
  logic         copi_d [2];
  logic         cipo_o [2];
  logic         oe_o   [2];
  logic         wrv_o  [2];
  logic         ferr_o [2];
  logic [31:0]  wra_o  [2];
  logic [255:0] regs_o [2];

  assign bus0.sclk = sclk_d[0];
  assign bus0.ncs  = ncs_d[0];
  assign bus0.copi = copi_d[0];
  assign bus1.sclk = sclk_d[1];
  assign bus1.ncs  = ncs_d[1];
  assign bus1.copi = copi_d[1];
  assign cipo_o[0] = bus0.cipo;
  assign cipo_o[1] = bus1.cipo;
  assign oe_o[0]   = bus0.cipo_oe;
  assign oe_o[1]   = bus1.cipo_oe;
  assign wrv_o[0]  = bus0.wr_valid;
  assign wrv_o[1]  = bus1.wr_valid;
  assign ferr_o[0] = bus0.frame_err;
  assign ferr_o[1] = bus1.frame_err;
  assign wra_o[0]  = 32'(bus0.wr_addr);
  assign wra_o[1]  = 32'(bus1.wr_addr);
  assign regs_o[0] = 256'(bus0.regs_out);
  assign regs_o[1] = bus1.regs_out;

  int p_a [2] = '{7, 4};
  int p_d [2] = '{8, 16};
  int p_n [2] = '{8, 16};
  int p_s [2] = '{2, 3};

  // Reference model and bookkeeping
  logic [15:0] m_regs [2][16];
  int m_wra [2];
  int e_wr  [2];
  int e_err [2];
  int n_wr  [2];
  int n_err [2];
  int compared   = 0;
  int mismatched = 0;

  // Count high cycles of each pulse; a pulse wider than one cycle shows up as extra counts
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wrv_o[k] === 1'b1)  n_wr[k]  <= n_wr[k] + 1;
      if (ferr_o[k] === 1'b1) n_err[k] <= n_err[k] + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Value of frame bits first..first+len-1 (bit 1 is the first bit on the wire)
  function automatic int field(input logic [31:0] f, input int nbits, input int first, input int len);
    int v;
    v = 0;
    for (int i = first; i < first + len; i++) v = (v << 1) | int'(f[nbits - i]);
    return v;
  endfunction

  function automatic logic [255:0] model_vec(input int k);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < p_n[k]; i++)
      for (int b = 0; b < p_d[k]; b++) v[i*p_d[k] + b] = m_regs[k][i][b];
    return v;
  endfunction

  // Frame outcome at ncs rise, from the frame rules
  task automatic apply_model(input int k, input logic [31:0] f, input int nbits);
    int fr;
    int ad;
    fr = 1 + p_a[k] + p_d[k];
    if (nbits == fr) begin
      ad = field(f, nbits, 2, p_a[k]);
      if (ad >= p_n[k]) begin
        e_err[k]++;
      end else if (f[fr-1] == 1'b1) begin
        m_regs[k][ad] = 16'(field(f, nbits, 2 + p_a[k], p_d[k]));
        m_wra[k] = ad;
        e_wr[k]++;
      end
    end else if (nbits != 0) begin
      e_err[k]++;
    end
  endtask

  // Shift nbits of f out MSB first, checking cipo/cipo_oe before every sclk rise
  task automatic send_frame(input int k, input logic [31:0] f, input int nbits, input bit raise);
    int a;
    int d;
    int ra;
    int m;
    bit rd_load;
    bit e_oe;
    logic e_cipo;
    logic [15:0] shadow;
    a = p_a[k];
    d = p_d[k];
    rd_load = (nbits >= 1 + a) && (f[nbits-1] == 1'b0);
    ra = (nbits >= 1 + a) ? field(f, nbits, 2, a) : 0;
    shadow = (rd_load && ra < p_n[k]) ? m_regs[k][ra] : 16'h0;
    ncs_d[k] = 1'b0;
    wait_clk(HALF);
    for (int j = 1; j <= nbits; j++) begin
      copi_d[k] = f[nbits-j];
      wait_clk(HALF);
      e_oe = rd_load && (j > 1 + a);
      m = j - 1 - a;
      e_cipo = (e_oe && m <= d) ? shadow[d - m] : 1'b0;
      chk($sformatf("dut%0d cipo_oe rise%0d", k, j), 256'(oe_o[k]), 256'(e_oe));
      chk($sformatf("dut%0d cipo rise%0d", k, j), 256'(cipo_o[k]), 256'(e_cipo));
      sclk_d[k] = 1'b1;
      wait_clk(HALF);
      sclk_d[k] = 1'b0;
    end
    wait_clk(HALF);
    if (raise) begin
      ncs_d[k] = 1'b1;
      apply_model(k, f, nbits);
    end
  endtask

  task automatic check_state(input int k, input string tag);
    wait_clk(14);
    chk($sformatf("%s dut%0d wr_valid pulses", tag, k), 256'(n_wr[k]), 256'(e_wr[k]));
    chk($sformatf("%s dut%0d frame_err pulses", tag, k), 256'(n_err[k]), 256'(e_err[k]));
    chk($sformatf("%s dut%0d regs_out", tag, k), regs_o[k], model_vec(k));
    chk($sformatf("%s dut%0d wr_addr", tag, k), 256'(wra_o[k]), 256'(m_wra[k]));
    chk($sformatf("%s dut%0d idle cipo_oe", tag, k), 256'(oe_o[k]), 256'(0));
    chk($sformatf("%s dut%0d idle cipo", tag, k), 256'(cipo_o[k]), 256'(0));
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_regs[k][i] = 16'h0;
      m_wra[k] = 0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int a, d, n, fr, nb, sel, ad, rw, dat;
    logic [31:0] full;
    logic [31:0] f;

    for (int k = 0; k < 2; k++) begin
      sclk_d[k] = 1'b0;
      ncs_d[k]  = 1'b1;
      copi_d[k] = 1'b0;
      e_wr[k]   = 0;
      e_err[k]  = 0;
    end
    clear_model();
    rst_n = 1'b0;
    wait_clk(4);
    chk("in-reset dut0 regs_out", regs_o[0], 256'(0));
    chk("in-reset dut0 wr_valid", 256'(wrv_o[0]), 256'(0));
    rst_n = 1'b1;
    check_state(0, "reset");
    check_state(1, "reset");

    // Write reg2 = A5 and measure commit latency from the raw ncs rise
    send_frame(0, 32'h82A5, 16, 1'b0);
    ncs_d[0] = 1'b1;
    apply_model(0, 32'h82A5, 16);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (wrv_o[0] === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("write latency", 256'(lat), 256'(p_s[0] + 1));
    check_state(0, "write reg2");

    // Read-back of reg2
    send_frame(0, 32'h0200, 16, 1'b1);
    check_state(0, "read reg2");

    // Short (12-bit) and long (17-bit) frames
    send_frame(0, 32'h83FF >> 4, 12, 1'b1);
    check_state(0, "short frame");
    send_frame(0, 32'h107FF, 17, 1'b1);
    check_state(0, "long frame");

    // Out-of-range write and read of address 8
    send_frame(0, 32'h8877, 16, 1'b1);
    check_state(0, "oor write");
    send_frame(0, 32'h0800, 16, 1'b1);
    check_state(0, "oor read");

    // sclk toggling while ncs is high is ignored
    for (int i = 0; i < 3; i++) begin
      copi_d[0] = 1'b1;
      sclk_d[0] = 1'b1;
      wait_clk(HALF);
      sclk_d[0] = 1'b0;
      wait_clk(HALF);
    end
    check_state(0, "sclk idle");

    // Sweep instance: write reg15 = BEEF, then read it back after the minimum ncs gap
    send_frame(1, 32'h1FBEEF, 21, 1'b1);
    wait_clk(p_s[1] + 2);
    send_frame(1, 32'h0F0000, 21, 1'b1);
    check_state(1, "sweep b2b");
    chk("sweep reg15", regs_o[1][255:240], 256'(16'hBEEF));

    // Reset mid-frame after 10 bits of 8155, release with ncs still low
    send_frame(0, 32'h8155 >> 6, 10, 1'b0);
    rst_n = 1'b0;
    wait_clk(3);
    clear_model();
    chk("mid-reset dut0 regs_out", regs_o[0], 256'(0));
    chk("mid-reset dut1 regs_out", regs_o[1], 256'(0));
    chk("mid-reset frame_err", 256'(ferr_o[0]), 256'(0));
    chk("mid-reset cipo_oe", 256'(oe_o[0]), 256'(0));
    rst_n = 1'b1;
    wait_clk(8);
    for (int i = 0; i < 3; i++) begin
      sclk_d[0] = 1'b1;
      wait_clk(HALF);
      sclk_d[0] = 1'b0;
      wait_clk(HALF);
    end
    ncs_d[0] = 1'b1;
    check_state(0, "post reset");
    check_state(1, "post reset");
    send_frame(0, 32'h8155, 16, 1'b1);
    check_state(0, "reg1 write");
    chk("reg1 value", regs_o[0][15:8], 256'(8'h55));

    // Randomised frames against the model
    for (int k = 0; k < 2; k++) begin
      a  = p_a[k];
      d  = p_d[k];
      n  = p_n[k];
      fr = 1 + a + d;
      for (int t = 0; t < 12; t++) begin
        rw  = int'($urandom_range(0, 1));
        ad  = int'($urandom_range(0, (k == 0) ? n + 1 : n - 1));
        dat = int'($urandom_range(0, (1 << d) - 1));
        full = 32'((rw << (a + d)) | (ad << d) | dat);
        sel = int'($urandom_range(0, 9));
        if (sel < 7) begin
          nb = fr;
          f  = full;
        end else if (sel < 9) begin
          nb = int'($urandom_range(1, fr - 1));
          f  = full >> (fr - nb);
        end else begin
          nb = fr + 1;
          f  = (full << 1) | 32'($urandom_range(0, 1));
        end
        send_frame(k, f, nb, 1'b1);
        wait_clk(p_s[k] + 2);
      end
      check_state(k, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
